// File: rtl/recon_stream_parser.sv
// Recon header parser: strips the header from store frames, forwards the realigned payload,
// keeps a slot table of stored bitstreams and issues DMA read descriptors for loads.
module recon_stream_parser #(
    parameter int DATA_WIDTH    = 512,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int HDR_OFFSET    = 46,
    parameter int ADDR_WIDTH    = 34,
    parameter int SLOT_COUNT    = 16,
    parameter int DMA_LEN_WIDTH = 20,
    parameter int DMA_TAG_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [ADDR_WIDTH-1:0]    m_base_addr,
    output logic                     m_base_addr_valid,
    output logic [ADDR_WIDTH-1:0]    m_read_desc_addr,
    output logic [DMA_LEN_WIDTH-1:0] m_read_desc_len,
    output logic [DMA_TAG_WIDTH-1:0] m_read_desc_tag,
    output logic                     m_read_desc_valid,
    input  logic                     m_read_desc_ready,
    output logic                     stat_len_err,
    output logic                     stat_lookup_miss,
    output logic                     stat_bad_func,
    output logic                     busy
);

    localparam int S      = HDR_OFFSET + 10;
    localparam int R      = KEEP_WIDTH - S;
    localparam int SLOT_W = $clog2(SLOT_COUNT);

    typedef enum logic [2:0] {IDLE, STORE, FLUSH, DMA_REQ, DROP} state_t;
    state_t state, state_next;

    logic [76:0]            hdr;
    logic [1:0]             h_func;
    logic                   h_sv;
    logic [ADDR_WIDTH-1:0]  h_addr;
    logic [7:0]             h_id;
    logic [31:0]            h_size;
    logic [SLOT_W-1:0]      h_slot;

    assign hdr    = s_axis_tdata[HDR_OFFSET*8 +: 77];
    assign h_func = hdr[1:0];
    assign h_sv   = hdr[2];
    assign h_addr = hdr[3 +: ADDR_WIDTH];
    assign h_id   = hdr[37 +: 8];
    assign h_size = hdr[45 +: 32];
    assign h_slot = h_id[SLOT_W-1:0];

    logic [ADDR_WIDTH-1:0]    slot_addr [SLOT_COUNT];
    logic [DMA_LEN_WIDTH-1:0] slot_len  [SLOT_COUNT];
    logic [SLOT_COUNT-1:0]    slot_valid;

    logic [R*8-1:0]        res_data;
    logic [R-1:0]          res_keep;
    logic [31:0]           count;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [SLOT_W-1:0]     st_slot;
    logic [31:0]           st_size;
    logic                  st_sv;
    logic                  ld_pending;

    logic [DATA_WIDTH-1:0] out_data;
    logic [KEEP_WIDTH-1:0] out_keep;
    logic                  out_valid;
    logic                  out_last;

    logic                  in_hs, idle_acc, out_free;
    logic [31:0]           pop_all, pop_hi, cnt_sum;
    logic [32:0]           sum_wide;

    logic                  fin_en, fin_bad, fin_sv;
    logic [31:0]           fin_count, fin_size;
    logic [SLOT_W-1:0]     fin_slot;
    logic [ADDR_WIDTH-1:0] fin_addr;

    function automatic logic [31:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [31:0] c;
        c = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) c = c + 32'(k[i]);
        return c;
    endfunction

    assign in_hs    = s_axis_tvalid && s_axis_tready;
    assign idle_acc = (state == IDLE) && in_hs;
    assign out_free = !out_valid || m_axis_tready;
    assign pop_all  = popcount(s_axis_tkeep);
    assign pop_hi   = popcount(s_axis_tkeep >> S);
    assign sum_wide = {1'b0, count} + {1'b0, pop_all};
    assign cnt_sum  = sum_wide[32] ? '1 : sum_wide[31:0];

    // A store ends from one of three places; the header fields are still on the bus for the single-beat case.
    always_comb begin
        fin_en    = 1'b0;
        fin_count = count;
        fin_slot  = st_slot;
        fin_addr  = st_addr;
        fin_size  = st_size;
        fin_sv    = st_sv;
        if (idle_acc && h_func == 2'b00 && s_axis_tlast && !s_axis_tkeep[S]) begin
            fin_en    = 1'b1;
            fin_count = pop_hi;
            fin_slot  = h_slot;
            fin_addr  = h_addr;
            fin_size  = h_size;
            fin_sv    = h_sv;
        end else if (state == STORE && in_hs && s_axis_tlast && !s_axis_tkeep[S]) begin
            fin_en    = 1'b1;
            fin_count = cnt_sum;
        end else if (state == FLUSH && out_free) begin
            fin_en = 1'b1;
        end
    end
    assign fin_bad = fin_sv && (fin_count != fin_size);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (s_axis_tvalid) begin
                    unique case (h_func)
                        2'b00: begin
                            if (!s_axis_tlast)         state_next = STORE;
                            else if (s_axis_tkeep[S])  state_next = FLUSH;
                        end
                        2'b01: begin
                            if (!s_axis_tlast)         state_next = DROP;
                            else if (slot_valid[h_slot]) state_next = DMA_REQ;
                        end
                        default: begin
                            if (!s_axis_tlast)         state_next = DROP;
                        end
                    endcase
                end
            end
            STORE:   if (in_hs && s_axis_tlast) state_next = s_axis_tkeep[S] ? FLUSH : IDLE;
            FLUSH:   if (out_free) state_next = IDLE;
            DMA_REQ: if (m_read_desc_ready) state_next = IDLE;
            DROP:    if (s_axis_tvalid && s_axis_tlast) state_next = ld_pending ? DMA_REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready     = 1'b0;
        m_read_desc_valid = 1'b0;
        busy              = (state != IDLE);
        unique case (state)
            IDLE, DROP: s_axis_tready = !rst;
            STORE:      s_axis_tready = !rst && out_free;
            DMA_REQ:    m_read_desc_valid = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid        <= '0;
            res_data          <= '0;
            res_keep          <= '0;
            count             <= '0;
            st_addr           <= '0;
            st_slot           <= '0;
            st_size           <= '0;
            st_sv             <= 1'b0;
            ld_pending        <= 1'b0;
            out_data          <= '0;
            out_keep          <= '0;
            out_valid         <= 1'b0;
            out_last          <= 1'b0;
            m_base_addr       <= '0;
            m_base_addr_valid <= 1'b0;
            m_read_desc_addr  <= '0;
            m_read_desc_len   <= '0;
            m_read_desc_tag   <= '0;
            stat_len_err      <= 1'b0;
            stat_lookup_miss  <= 1'b0;
            stat_bad_func     <= 1'b0;
        end else begin
            m_base_addr_valid <= 1'b0;
            stat_len_err      <= 1'b0;
            stat_lookup_miss  <= 1'b0;
            stat_bad_func     <= 1'b0;
            if (out_valid && m_axis_tready) out_valid <= 1'b0;

            if (idle_acc) begin
                ld_pending <= (h_func == 2'b01) && slot_valid[h_slot];
                unique case (h_func)
                    2'b00: begin
                        m_base_addr       <= h_addr;
                        m_base_addr_valid <= 1'b1;
                        st_addr           <= h_addr;
                        st_slot           <= h_slot;
                        st_size           <= h_size;
                        st_sv             <= h_sv;
                        res_data          <= s_axis_tdata[DATA_WIDTH-1 -: R*8];
                        res_keep          <= s_axis_tkeep[KEEP_WIDTH-1 -: R];
                        count             <= pop_hi;
                    end
                    2'b01: begin
                        m_read_desc_addr <= slot_addr[h_slot];
                        m_read_desc_len  <= slot_len[h_slot];
                        m_read_desc_tag  <= DMA_TAG_WIDTH'(h_id);
                        stat_lookup_miss <= !slot_valid[h_slot];
                    end
                    2'b10:   slot_valid[h_slot] <= 1'b0;
                    default: stat_bad_func <= 1'b1;
                endcase
            end

            if (state == STORE && in_hs) begin
                out_data  <= {s_axis_tdata[S*8-1:0], res_data};
                out_keep  <= {s_axis_tkeep[S-1:0], res_keep};
                out_valid <= 1'b1;
                out_last  <= s_axis_tlast && !s_axis_tkeep[S];
                res_data  <= s_axis_tdata[DATA_WIDTH-1 -: R*8];
                res_keep  <= s_axis_tkeep[KEEP_WIDTH-1 -: R];
                count     <= cnt_sum;
            end

            if (state == FLUSH && out_free) begin
                out_data  <= {{(DATA_WIDTH-R*8){1'b0}}, res_data};
                out_keep  <= {{S{1'b0}}, res_keep};
                out_valid <= 1'b1;
                out_last  <= 1'b1;
            end

            if (fin_en) begin
                if (fin_bad) stat_len_err <= 1'b1;
                else         slot_valid[fin_slot] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fin_en && !fin_bad) begin
            slot_addr[fin_slot] <= fin_addr;
            slot_len[fin_slot]  <= fin_count[DMA_LEN_WIDTH-1:0];
        end
    end

    assign m_axis_tdata  = out_data;
    assign m_axis_tkeep  = out_keep;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;

endmodule
